// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: MAR load, read/write strobe with a ready wait and timeout,
// then an MDR capture for reads. Moore FSM, so every output decodes from state alone.
module mem_access_ctrl #(
  parameter int unsigned MIN_WAIT = 2,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       req,
  input  logic       we,
  input  logic       mem_ready,
  output logic       MARin,
  output logic       MDRin,
  output logic       read,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] state_dbg
);

  // Handshake: req is sampled only in IDLE; one accepted req yields exactly one
  // done pulse (with error on timeout). req while busy is dropped, never queued.

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_MAR = 3'd1,
    ACCESS   = 3'd2,
    CAPTURE  = 3'd3,
    DONE     = 3'd4,
    ABORT    = 3'd5
  } state_t;

  localparam logic [7:0] MIN_WAIT_C = 8'(MIN_WAIT);
  localparam logic [7:0] LAST_C     = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] wait_cnt;
  logic       we_q;
  logic       ready_ok;
  logic       timed_out;

  assign ready_ok  = (wait_cnt >= MIN_WAIT_C) && mem_ready;
  assign timed_out = (wait_cnt == LAST_C);
  assign state_dbg = state;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Counter restarts in LOAD_MAR so it reads 0 in the first ACCESS cycle.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      wait_cnt <= 8'd0;
      we_q     <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        we_q <= we;
      end
      if (state == LOAD_MAR) begin
        wait_cnt <= 8'd0;
      end else if (state == ACCESS && wait_cnt != 8'hFF) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (req) state_next = LOAD_MAR;
      LOAD_MAR: state_next = ACCESS;
      ACCESS: begin
        if (ready_ok) begin
          state_next = we_q ? DONE : CAPTURE;
        end else if (timed_out) begin
          state_next = ABORT;
        end
      end
      CAPTURE:  state_next = DONE;
      DONE:     state_next = IDLE;
      ABORT:    state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    MARin  = 1'b0;
    MDRin  = 1'b0;
    read   = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    busy   = (state != IDLE);
    done   = 1'b0;
    error  = 1'b0;
    case (state)
      LOAD_MAR: MARin = 1'b1;
      ACCESS: begin
        mem_rd = ~we_q;
        mem_wr = we_q;
      end
      // Strobe stays up so Mdatain is still valid while the MDR loads.
      CAPTURE: begin
        read   = 1'b1;
        MDRin  = 1'b1;
        mem_rd = 1'b1;
      end
      DONE:  done = 1'b1;
      ABORT: begin
        done  = 1'b1;
        error = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: randomized transactions scored against a per-transaction
// summary computed from the latency/timeout rules, plus directed reset and clear cases.
module tb_mem_access_ctrl;

  localparam int MIN_WAIT = 2;
  localparam int TIMEOUT  = 16;

  typedef struct packed {
    logic        err;
    logic [7:0]  lat;
    logic [7:0]  rd_c;
    logic [7:0]  wr_c;
    logic [7:0]  mdrin_c;
    logic [7:0]  read_c;
    logic [7:0]  marin_c;
    logic [7:0]  busy_c;
    logic [7:0]  gap;
    logic [31:0] mdr;
  } txn_t;

  localparam int TXN_W = $bits(txn_t);

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       req = 1'b0;
  logic       we = 1'b0;
  logic       mem_ready = 1'b0;
  logic       MARin, MDRin, read, mem_rd, mem_wr, busy, done, error;
  logic [2:0] state_dbg;

  logic [31:0] mdr = 32'h12345678;
  logic [31:0] mdatain = 32'h0;
  logic [31:0] busmux = 32'h0;
  logic [31:0] exp_mdr = 32'h12345678;

  logic [TXN_W-1:0] exp_q[$];

  int checks = 0;
  int passes = 0;
  int fails = 0;
  bit prev_chain = 0;

  // monitor state
  int cyc = 0;
  bit in_txn = 0;
  int start_cyc, last_done = 0, gap_obs;
  int c_marin, c_rd, c_wr, c_mdrin, c_read, c_busy;
  int viol = 0;

  mem_access_ctrl #(.MIN_WAIT(MIN_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .clear(clear), .req(req), .we(we), .mem_ready(mem_ready),
    .MARin(MARin), .MDRin(MDRin), .read(read), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .busy(busy), .done(done), .error(error), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  // MDR register fed by the controller's mux select and load enable
  always @(posedge clock) begin
    if (MDRin) mdr <= read ? mdatain : busmux;
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act === exp) passes++;
    else begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {MARin, MDRin, read, mem_rd, mem_wr, busy, done, error};
  endfunction

  // One transaction: d = ACCESS cycle (counter value) at which mem_ready rises,
  // glitch = pulse ready during the ignored window, chain = keep req high at done.
  task automatic run_txn(input logic w, input int d, input bit chain, input bit glitch,
                         input logic [31:0] data);
    int   i, eff, access, cap, acc;
    bit   err, seen_done;
    txn_t e;
    i = 0;
    @(negedge clock);
    while (busy && i < 200) begin
      @(negedge clock);
      i++;
    end
    check("idle_wait", busy, 0);
    we      = w;
    mdatain = data;
    busmux  = $urandom;
    eff     = (d > MIN_WAIT) ? d : MIN_WAIT;
    err     = (eff > TIMEOUT - 1);
    access  = err ? TIMEOUT : eff + 1;
    cap     = (!w && !err) ? 1 : 0;
    if (cap == 1) exp_mdr = data;
    e.err     = err;
    e.lat     = 8'(1 + access + cap);
    e.rd_c    = w ? 8'd0 : 8'(access + cap);
    e.wr_c    = w ? 8'(access) : 8'd0;
    e.mdrin_c = 8'(cap);
    e.read_c  = 8'(cap);
    e.marin_c = 8'd1;
    e.busy_c  = 8'(2 + access + cap);
    e.gap     = prev_chain ? 8'd2 : 8'd0;
    e.mdr     = exp_mdr;
    exp_q.push_back(e);
    req = 1'b1;
    i = 0;
    seen_done = 0;
    while (!seen_done && i < 300) begin
      @(negedge clock);
      i++;
      acc = i - 2;
      mem_ready = (acc >= d) || (glitch && acc >= 0 && acc < MIN_WAIT);
      if (done) begin
        seen_done = 1;
        req = chain;
        mem_ready = 1'b0;
      end else begin
        we = 1'($urandom);
        if (!chain) req = 1'($urandom);
      end
    end
    check("done_seen", seen_done, 1);
    if (!seen_done) begin
      req = 1'b0;
      mem_ready = 1'b0;
    end
    prev_chain = chain && seen_done;
  endtask

  // monitor: builds an observed summary per transaction and scores it on done
  initial begin
    txn_t e;
    forever begin
      @(negedge clock);
      cyc++;
      if (clear) in_txn = 0;
      else if (MARin && !in_txn) begin
        in_txn = 1;
        start_cyc = cyc;
        gap_obs = cyc - last_done;
        c_marin = 0; c_rd = 0; c_wr = 0; c_mdrin = 0; c_read = 0; c_busy = 0;
      end
      if (mem_rd && mem_wr) viol++;
      if (MARin && MDRin) viol++;
      if (read != MDRin) viol++;
      if (error && !done) viol++;
      if (busy != in_txn) viol++;
      if (in_txn) begin
        c_marin += int'(MARin);
        c_rd    += int'(mem_rd);
        c_wr    += int'(mem_wr);
        c_mdrin += int'(MDRin);
        c_read  += int'(read);
        c_busy  += int'(busy);
      end
      if (done) begin
        check("exp_avail", exp_q.size() != 0, 1);
        check("done_in_txn", in_txn, 1);
        if (exp_q.size() != 0) begin
          e = txn_t'(exp_q.pop_front());
          check("latency", cyc - start_cyc, e.lat);
          check("error", error, e.err);
          check("mem_rd_cycles", c_rd, e.rd_c);
          check("mem_wr_cycles", c_wr, e.wr_c);
          check("mdrin_cycles", c_mdrin, e.mdrin_c);
          check("read_cycles", c_read, e.read_c);
          check("marin_cycles", c_marin, e.marin_c);
          check("busy_cycles", c_busy, e.busy_c);
          check("mdr", mdr, e.mdr);
          check("invariants", viol, 0);
          viol = 0;
          if (e.gap != 0) check("req_gap", gap_obs, e.gap);
        end
        in_txn = 0;
        last_done = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ch;
    #2 clear = 1'b1;
    #1 check("reset_outs", outs(), 8'h00);
    repeat (2) @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    check("idle_outs", outs(), 8'h00);

    // timeout keeps the preset MDR, then read, write, ready exactly at last ACCESS cycle
    run_txn(1'b0, 255, 0, 0, 32'hCAFEF00D);
    run_txn(1'b0, 0, 0, 0, 32'hDEADBEEF);
    run_txn(1'b1, 4, 0, 0, 32'h0BADF00D);
    run_txn(1'b0, TIMEOUT - 1, 0, 0, 32'h600DD00D);
    run_txn(1'b1, TIMEOUT, 0, 0, 32'h11111111);
    run_txn(1'b0, 5, 0, 1, 32'hA5A5A5A5);

    // clear mid-ACCESS, between clock edges
    @(negedge clock);
    we = 1'b0;
    req = 1'b1;
    @(negedge clock);
    req = 1'b0;
    repeat (2) @(negedge clock);
    check("clr_pre_rd", mem_rd, 1);
    #2 clear = 1'b1;
    #1 check("clr_outs", outs(), 8'h00);
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    check("clr_idle", outs(), 8'h00);
    run_txn(1'b0, 1, 0, 0, 32'h55AA55AA);

    // req held high: back-to-back reads
    for (int k = 0; k < 4; k++) run_txn(1'b0, 0, k < 3, 0, $urandom);

    for (int k = 0; k < 30; k++) begin
      ch = ($urandom_range(0, 3) == 0) && (k != 29);
      run_txn(1'($urandom), $urandom_range(0, 20), ch, 1'($urandom), $urandom);
    end

    repeat (5) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);
    check("invariants_tail", viol, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
